// File: rtl/sprite_linebuf_ctrl_pkg.sv
// Shared definitions for the sprite line-buffer controller: FSM encoding and buffer geometry.
package sprite_linebuf_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRender   = 2'd1,
    StDoneWait = 2'd2
  } sprite_state_e;

  localparam int unsigned LinePixels         = 640;
  localparam int unsigned LineBanks          = 4;
  // One erase clears one pixel per bank per cycle.
  localparam int unsigned DefaultEraseCycles = LinePixels / LineBanks;

endpackage

// File: rtl/sprite_linebuf_ctrl_erase_timer.sv
// Erase timer: a load pulse restarts a down-counter that mirrors the line-buffer erase.
// start_o pulses the cycle after load, busy_o covers ERASE_CYCLES cycles from that point,
// done_o flags the last busy cycle unless a reload arrives in it.
module sprite_linebuf_ctrl_erase_timer
  import sprite_linebuf_ctrl_pkg::*;
#(
  parameter int unsigned ERASE_CYCLES = DefaultEraseCycles
) (
  input  logic clk,
  input  logic rst,
  input  logic load_i,
  output logic start_o,
  output logic busy_o,
  output logic done_o
);

  localparam int unsigned CntW = $clog2(ERASE_CYCLES + 1);
  localparam logic [CntW-1:0] LoadVal = CntW'(ERASE_CYCLES);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            start_q;

  // Next count: reload wins, otherwise count down to zero and hold.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LoadVal;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  // Counter and start pulse state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      start_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      start_q <= load_i;
    end
  end

  assign start_o = start_q;
  assign busy_o  = (cnt_q != '0);
  assign done_o  = (cnt_q == CntW'(1)) && !load_i;

endmodule

// File: rtl/sprite_linebuf_ctrl.sv
// Sprite line-buffer sequencer: ping-pong select, renderer start/abort handshakes,
// deferred swap while the composer-side erase is still running, and overrun status.
module sprite_linebuf_ctrl
  import sprite_linebuf_ctrl_pkg::*;
#(
  parameter int unsigned ERASE_CYCLES = DefaultEraseCycles,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             line_start_i,
  input  logic             composer_line_end_i,
  input  logic             renderer_done_i,
  input  logic             status_clear_i,
  output logic             active_render_buffer_o,
  output logic             renderer_start_o,
  output logic             renderer_abort_o,
  output logic             composer_erase_start_o,
  output logic             erase_busy_o,
  output logic             swap_pending_o,
  output logic [CNT_W-1:0] overrun_cnt_o,
  output logic             erase_late_o
);

  sprite_state_e    state_q, state_d;
  logic             act_q, act_d;
  logic             start_q, start_d;
  logic             abort_q, abort_d;
  logic             pending_q, pending_d;
  logic             start_pend_q, start_pend_d;
  logic [CNT_W-1:0] overrun_q, overrun_d;
  logic             late_q, late_d;

  logic erase_busy, erase_done;
  logic waiting, new_swap, in_render, abort_ev, overrun_ev, swap_new_now, swap_late_now;

  sprite_linebuf_ctrl_erase_timer #(
    .ERASE_CYCLES (ERASE_CYCLES)
  ) u_erase_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (composer_line_end_i),
    .start_o (composer_erase_start_o),
    .busy_o  (erase_busy),
    .done_o  (erase_done)
  );

  // Decode line events and compute every next-state value for the single state register block.
  always_comb begin
    // A deferred swap is only outstanding while the erase it waits for is still running.
    waiting       = pending_q & erase_busy;
    new_swap      = line_start_i & ~waiting;
    in_render     = (state_q == StRender);
    abort_ev      = line_start_i & in_render & ~renderer_done_i & ~waiting;
    overrun_ev    = abort_ev | (line_start_i & waiting);
    swap_new_now  = new_swap & (~erase_busy | erase_done);
    swap_late_now = waiting & erase_done;

    state_d = state_q;
    unique case (state_q)
      StIdle:     if (line_start_i && enable_i) state_d = StRender;
      StRender: begin
        if (line_start_i)         state_d = enable_i ? StRender : StIdle;
        else if (renderer_done_i) state_d = StDoneWait;
      end
      StDoneWait: if (line_start_i) state_d = enable_i ? StRender : StIdle;
      default:    state_d = StIdle;
    endcase

    // Latest line_start decides whether the eventual swap also starts the renderer.
    start_pend_d = line_start_i ? enable_i : start_pend_q;

    act_d   = (swap_new_now | swap_late_now) ? ~act_q : act_q;
    start_d = swap_new_now ? enable_i : (swap_late_now & start_pend_d);
    abort_d = abort_ev;

    // Pending stays up through the swap cycle and drops once the erase has finished.
    pending_d = pending_q;
    if (new_swap && erase_busy)          pending_d = 1'b1;
    else if (pending_q && !erase_busy)   pending_d = 1'b0;

    overrun_d = overrun_q;
    if (status_clear_i) overrun_d = '0;
    else if (overrun_ev && (overrun_q != {CNT_W{1'b1}})) overrun_d = overrun_q + CNT_W'(1);

    late_d = late_q;
    if (status_clear_i)               late_d = 1'b0;
    else if (new_swap && erase_busy)  late_d = 1'b1;
  end

  // FSM, select, registered pulses and status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      act_q        <= 1'b0;
      start_q      <= 1'b0;
      abort_q      <= 1'b0;
      pending_q    <= 1'b0;
      start_pend_q <= 1'b0;
      overrun_q    <= '0;
      late_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_q        <= act_d;
      start_q      <= start_d;
      abort_q      <= abort_d;
      pending_q    <= pending_d;
      start_pend_q <= start_pend_d;
      overrun_q    <= overrun_d;
      late_q       <= late_d;
    end
  end

  assign active_render_buffer_o = act_q;
  assign renderer_start_o       = start_q;
  assign renderer_abort_o       = abort_q;
  assign erase_busy_o           = erase_busy;
  assign swap_pending_o         = pending_q;
  assign overrun_cnt_o          = overrun_q;
  assign erase_late_o           = late_q;

endmodule

// File: tb/tb_sprite_linebuf_ctrl.sv
// Directed bench for sprite_linebuf_ctrl: normal lines, overrun and saturation, erase timing,
// deferred swap, same-cycle priorities, async reset and sprite layer disable.
module tb_sprite_linebuf_ctrl;

  logic       clk, rst;
  logic       enable, line_start, composer_line_end, renderer_done, status_clear;
  logic       active_render_buffer, renderer_start, renderer_abort, composer_erase_start;
  logic       erase_busy, swap_pending, erase_late;
  logic [7:0] overrun_cnt;

  int tests = 0;
  int fails = 0;
  logic exp_act = 1'b0;
  int   start_cnt;

  sprite_linebuf_ctrl #(
    .ERASE_CYCLES (160),
    .CNT_W        (8)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .enable_i               (enable),
    .line_start_i           (line_start),
    .composer_line_end_i    (composer_line_end),
    .renderer_done_i        (renderer_done),
    .status_clear_i         (status_clear),
    .active_render_buffer_o (active_render_buffer),
    .renderer_start_o       (renderer_start),
    .renderer_abort_o       (renderer_abort),
    .composer_erase_start_o (composer_erase_start),
    .erase_busy_o           (erase_busy),
    .swap_pending_o         (swap_pending),
    .overrun_cnt_o          (overrun_cnt),
    .erase_late_o           (erase_late)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; line_start = 1'b0; composer_line_end = 1'b0;
    renderer_done = 1'b0; status_clear = 1'b0;
    #2;
    check("rst_act", 32'(active_render_buffer), 0);
    check("rst_start", 32'(renderer_start), 0);
    check("rst_busy", 32'(erase_busy), 0);
    check("rst_ovr", 32'(overrun_cnt), 0);
    #10 rst = 1'b0;
    cyc(3);

    // Normal line: swap and start the cycle after line_start, no overrun.
    line_start = 1'b1; cyc(1); line_start = 1'b0; exp_act = ~exp_act;
    check("n1_act", 32'(active_render_buffer), 32'(exp_act));
    check("n1_start", 32'(renderer_start), 1);
    check("n1_abort", 32'(renderer_abort), 0);
    cyc(1);
    check("n1_start_pulse", 32'(renderer_start), 0);
    cyc(20);
    renderer_done = 1'b1; cyc(1); renderer_done = 1'b0;
    cyc(30);
    line_start = 1'b1; cyc(1); line_start = 1'b0; exp_act = ~exp_act;
    check("n2_act", 32'(active_render_buffer), 32'(exp_act));
    check("n2_start", 32'(renderer_start), 1);
    check("n2_abort", 32'(renderer_abort), 0);
    check("n2_ovr", 32'(overrun_cnt), 0);

    // Overrun: line_start without renderer_done aborts and counts.
    cyc(10);
    line_start = 1'b1; cyc(1); exp_act = ~exp_act;
    check("ov1_abort", 32'(renderer_abort), 1);
    check("ov1_cnt", 32'(overrun_cnt), 1);
    check("ov1_start", 32'(renderer_start), 1);
    cyc(299); line_start = 1'b0;
    for (int i = 0; i < 299; i++) exp_act = ~exp_act;
    check("ov_sat", 32'(overrun_cnt), 255);
    check("ov_act", 32'(active_render_buffer), 32'(exp_act));

    // status_clear alone, then line_start with renderer_done in the same cycle.
    status_clear = 1'b1; cyc(1); status_clear = 1'b0;
    check("clr_ovr", 32'(overrun_cnt), 0);
    line_start = 1'b1; renderer_done = 1'b1; cyc(1);
    line_start = 1'b0; renderer_done = 1'b0; exp_act = ~exp_act;
    check("sim_abort", 32'(renderer_abort), 0);
    check("sim_ovr", 32'(overrun_cnt), 0);
    check("sim_start", 32'(renderer_start), 1);
    cyc(5);
    line_start = 1'b1; cyc(1); line_start = 1'b0; exp_act = ~exp_act;
    check("pre_clr_ovr", 32'(overrun_cnt), 1);
    cyc(5);
    line_start = 1'b1; status_clear = 1'b1; cyc(1);
    line_start = 1'b0; status_clear = 1'b0; exp_act = ~exp_act;
    check("clr_prio_ovr", 32'(overrun_cnt), 0);
    check("clr_prio_abort", 32'(renderer_abort), 1);
    renderer_done = 1'b1; cyc(1); renderer_done = 1'b0;
    cyc(5);

    // Erase timing: pulse M+1, busy M+1..M+160.
    composer_line_end = 1'b1; cyc(1); composer_line_end = 1'b0;
    check("er_start", 32'(composer_erase_start), 1);
    check("er_busy_first", 32'(erase_busy), 1);
    cyc(1);
    check("er_start_pulse", 32'(composer_erase_start), 0);
    cyc(158);
    check("er_busy_last", 32'(erase_busy), 1);
    cyc(1);
    check("er_busy_off", 32'(erase_busy), 0);
    cyc(5);

    // Late erase: erase at 50 (busy 51..210), line_start at 100, extra line_start at 150.
    composer_line_end = 1'b1; cyc(1); composer_line_end = 1'b0;  // now cycle 51
    cyc(49);                                                     // cycle 100
    line_start = 1'b1; cyc(1); line_start = 1'b0;                // cycle 101
    check("late_pend_101", 32'(swap_pending), 1);
    check("late_flag", 32'(erase_late), 1);
    check("late_nostart", 32'(renderer_start), 0);
    check("late_hold_act", 32'(active_render_buffer), 32'(exp_act));
    check("late_noabort", 32'(renderer_abort), 0);
    cyc(49);                                                     // cycle 150
    line_start = 1'b1; cyc(1); line_start = 1'b0;                // cycle 151
    check("late_ovr_pend", 32'(overrun_cnt), 1);
    check("late_pend_abort", 32'(renderer_abort), 0);
    cyc(59);                                                     // cycle 210
    check("late_pend_210", 32'(swap_pending), 1);
    check("late_act_210", 32'(active_render_buffer), 32'(exp_act));
    cyc(1); exp_act = ~exp_act;                                  // cycle 211
    check("late_act_211", 32'(active_render_buffer), 32'(exp_act));
    check("late_start_211", 32'(renderer_start), 1);
    check("late_pend_211", 32'(swap_pending), 1);
    cyc(1);                                                      // cycle 212
    check("late_pend_212", 32'(swap_pending), 0);
    check("late_start_212", 32'(renderer_start), 0);
    check("late_act_212", 32'(active_render_buffer), 32'(exp_act));

    // Async reset in the middle of an erase with a pending swap.
    composer_line_end = 1'b1; cyc(1); composer_line_end = 1'b0;
    cyc(30);
    line_start = 1'b1; cyc(1); line_start = 1'b0;
    cyc(40);
    #2 rst = 1'b1;
    #1;
    check("arst_act", 32'(active_render_buffer), 0);
    check("arst_busy", 32'(erase_busy), 0);
    check("arst_pend", 32'(swap_pending), 0);
    check("arst_ovr", 32'(overrun_cnt), 0);
    check("arst_late", 32'(erase_late), 0);
    check("arst_pulses", 32'({renderer_start, renderer_abort, composer_erase_start}), 0);
    #2 rst = 1'b0;
    cyc(1);
    check("arst_busy_after", 32'(erase_busy), 0);
    exp_act = 1'b0;

    // Sprite layer disabled: swaps continue, no renderer_start over 5 lines.
    enable = 1'b0;
    start_cnt = 0;
    for (int l = 0; l < 5; l++) begin
      line_start = 1'b1; cyc(1); line_start = 1'b0; exp_act = ~exp_act;
      start_cnt += int'(renderer_start);
      for (int c = 0; c < 8; c++) begin
        cyc(1);
        start_cnt += int'(renderer_start);
      end
    end
    check("dis_starts", 32'(start_cnt), 0);
    check("dis_act", 32'(active_render_buffer), 32'(exp_act));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
